// File: rtl/dma_pkg.sv
// Shared types, defaults and the priority-rotation helper for the DMA request arbiter.
package dma_pkg;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    GRANT    = 2'd2
  } state_t;

  localparam logic [2*DEFAULT_NUM_CH-1:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

  // Channel just served drops to the lowest slot; its successor takes slot 0.
  function automatic logic [2*DEFAULT_NUM_CH-1:0] rotate_order(input logic [DEFAULT_CH_W-1:0] k);
    logic [2*DEFAULT_NUM_CH-1:0] order;
    order = '0;
    for (int s = 0; s < DEFAULT_NUM_CH; s++) begin
      order[DEFAULT_CH_W*s +: DEFAULT_CH_W] = DEFAULT_CH_W'((int'(k) + 1 + s) % DEFAULT_NUM_CH);
    end
    return order;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational winner pick: first priority slot whose channel is requesting; zero latency, no flow control.
module dma_priority_encoder
  import dma_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CH_W   = DEFAULT_CH_W
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [2*NUM_CH-1:0] order,
  output logic [CH_W-1:0]     win_ch,
  output logic                win_vld
);

  // Scan from the lowest-priority slot upward so slot 0 overrides everything.
  always_comb begin
    win_ch  = '0;
    win_vld = 1'b0;
    for (int s = NUM_CH - 1; s >= 0; s--) begin
      if (req[order[CH_W*s +: CH_W]]) begin
        win_ch  = order[CH_W*s +: CH_W];
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// 8237-style request arbiter: HRQ one cycle after a request, DACK one cycle after HLDA, grant held until serviceDone/HLDA drop.
// Rotating priority exists only when DMA_ROTATING_PRIORITY_EN is defined; otherwise priorityOrder is constant.
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CH_W   = DEFAULT_CH_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic                HLDA,
  input  logic                priorityType,
  input  logic                dreqSense,
  input  logic                ctrlDisable,
  input  logic [NUM_CH-1:0]   maskReg,
  input  logic [NUM_CH-1:0]   swRequest,
  input  logic                serviceDone,
  output logic                HRQ,
  output logic [NUM_CH-1:0]   DACK,
  output logic                grantValid,
  output logic [CH_W-1:0]     grantCh,
  output logic [2*NUM_CH-1:0] priorityOrder
);

  state_t            state;
  logic [NUM_CH-1:0] req_eff;
  logic [CH_W-1:0]   win_ch;
  logic              win_vld;

  assign req_eff = ctrlDisable ? '0
                 : (((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | swRequest);

  dma_priority_encoder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_enc (
    .req     (req_eff),
    .order   (priorityOrder),
    .win_ch  (win_ch),
    .win_vld (win_vld)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      HRQ        <= 1'b0;
      DACK       <= '0;
      grantValid <= 1'b0;
      grantCh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_eff) begin
            state <= HOLD_REQ;
            HRQ   <= 1'b1;
          end
        end
        HOLD_REQ: begin
          if (!(|req_eff)) begin
            state <= IDLE;
            HRQ   <= 1'b0;
          end else if (HLDA && win_vld) begin
            state      <= GRANT;
            DACK       <= NUM_CH'(1) << win_ch;
            grantCh    <= win_ch;
            grantValid <= 1'b1;
          end
        end
        GRANT: begin
          // serviceDone wins over a simultaneous HLDA drop; both end the grant.
          if (serviceDone || !HLDA) begin
            state      <= IDLE;
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          HRQ        <= 1'b0;
          DACK       <= '0;
          grantValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [2*NUM_CH-1:0] order_q;

  // Only a completed service rotates; an HLDA abort leaves the order alone.
  always_ff @(posedge CLK) begin
    if (RESET || !priorityType) begin
      order_q <= DEFAULT_PRIORITY_ORDER;
    end else if (state == GRANT && serviceDone) begin
      order_q <= rotate_order(grantCh);
    end
  end

  assign priorityOrder = order_q;
`else
  logic unused_priority_type;

  assign unused_priority_type = priorityType;
  assign priorityOrder        = DEFAULT_PRIORITY_ORDER;
`endif

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Bench for dma_priority_resolver: directed scenarios plus randomized traffic against a behavioural model.
module tb_dma_priority_resolver;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       priorityType;
  logic       dreqSense;
  logic       ctrlDisable;
  logic [3:0] maskReg;
  logic [3:0] swRequest;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantCh;
  logic [7:0] priorityOrder;

  int checks   = 0;
  int failures = 0;

`ifdef DMA_ROTATING_PRIORITY_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  dma_priority_resolver dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .DREQ          (DREQ),
    .HLDA          (HLDA),
    .priorityType  (priorityType),
    .dreqSense     (dreqSense),
    .ctrlDisable   (ctrlDisable),
    .maskReg       (maskReg),
    .swRequest     (swRequest),
    .serviceDone   (serviceDone),
    .HRQ           (HRQ),
    .DACK          (DACK),
    .grantValid    (grantValid),
    .grantCh       (grantCh),
    .priorityOrder (priorityOrder)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: priority list as an array of channel numbers, handshake as a phase.
  int       m_ord[4];
  bit       m_hrq;
  bit [3:0] m_dack;
  bit       m_gv;
  int       m_gch;
  int       m_phase;   // 0 quiet, 1 asking CPU for the bus, 2 channel being served
  bit       m_prev_hlda;

  function automatic bit [3:0] model_eff();
    bit [3:0] r;
    r = 4'b0;
    if (!ctrlDisable)
      for (int i = 0; i < 4; i++)
        r[i] = ((DREQ[i] != dreqSense) && !maskReg[i]) || swRequest[i];
    return r;
  endfunction

  function automatic int model_pick(input bit [3:0] r);
    for (int s = 0; s < 4; s++)
      if (r[m_ord[s]]) return m_ord[s];
    return -1;
  endfunction

  function automatic logic [7:0] model_order();
    logic [7:0] p;
    for (int s = 0; s < 4; s++) p[2*s +: 2] = 2'(m_ord[s]);
    return p;
  endfunction

  always @(posedge CLK) begin
    bit [3:0] r;
    int       w;
    bit       served;
    int       k;
    m_prev_hlda = HLDA;
    served = 1'b0;
    k = m_gch;
    if (RESET) begin
      m_phase = 0; m_hrq = 0; m_dack = 0; m_gv = 0; m_gch = 0;
      for (int s = 0; s < 4; s++) m_ord[s] = s;
    end else begin
      r = model_eff();
      w = model_pick(r);
      if (m_phase == 0) begin
        if (r != 0) begin m_phase = 1; m_hrq = 1; end
      end else if (m_phase == 1) begin
        if (r == 0) begin
          m_phase = 0; m_hrq = 0;
        end else if (HLDA) begin
          m_phase = 2; m_dack = 4'b0001 << w; m_gch = w; m_gv = 1;
        end
      end else begin
        if (serviceDone || !HLDA) begin
          served = serviceDone;
          m_phase = 0; m_hrq = 0; m_dack = 0; m_gv = 0;
        end
      end
      if (!(ROT_EN && priorityType)) begin
        for (int s = 0; s < 4; s++) m_ord[s] = s;
      end else if (served) begin
        for (int s = 0; s < 4; s++) m_ord[s] = (k + 1 + s) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    DREQ = 4'b0; HLDA = 0; dreqSense = 0; ctrlDisable = 0;
    maskReg = 4'b0; swRequest = 4'b0; serviceDone = 0;
  endtask

  task automatic test_reset();
    RESET = 1; priorityType = 0;
    idle_inputs();
    tick(); tick();
    checks++; if (HRQ !== 1'b0) begin failures++; $display("FAIL reset_hrq got=%0b want=0", HRQ); end
    checks++; if (DACK !== 4'b0) begin failures++; $display("FAIL reset_dack got=%b want=0000", DACK); end
    checks++; if (grantValid !== 1'b0) begin failures++; $display("FAIL reset_gv got=%0b want=0", grantValid); end
    checks++; if (grantCh !== 2'd0) begin failures++; $display("FAIL reset_gch got=%0d want=0", grantCh); end
    checks++; if (priorityOrder !== 8'b11_10_01_00) begin failures++; $display("FAIL reset_order got=%b want=11100100", priorityOrder); end
    RESET = 0;
    tick();
  endtask

  task automatic test_fixed();
    logic [3:0] pats [3];
    logic [3:0] exps [3];
    logic [1:0] chs  [3];
    pats = '{4'b0110, 4'b1000, 4'b1111};
    exps = '{4'b0010, 4'b1000, 4'b0001};
    chs  = '{2'd1, 2'd3, 2'd0};
    priorityType = 0;
    for (int i = 0; i < 3; i++) begin
      DREQ = pats[i];
      tick();
      checks++; if (HRQ !== 1'b1) begin failures++; $display("FAIL fixed_hrq[%0d] got=%0b want=1", i, HRQ); end
      tick(); tick();
      checks++; if (DACK !== 4'b0) begin failures++; $display("FAIL fixed_no_dack_before_hlda[%0d] got=%b want=0000", i, DACK); end
      HLDA = 1;
      tick();
      checks++; if (DACK !== exps[i]) begin failures++; $display("FAIL fixed_dack[%0d] got=%b want=%b", i, DACK, exps[i]); end
      checks++; if (grantValid !== 1'b1 || grantCh !== chs[i]) begin failures++; $display("FAIL fixed_grant[%0d] got=%0b/%0d want=1/%0d", i, grantValid, grantCh, chs[i]); end
      DREQ = 4'b0;
      tick();
      checks++; if (DACK !== exps[i]) begin failures++; $display("FAIL fixed_hold_after_drop[%0d] got=%b want=%b", i, DACK, exps[i]); end
      serviceDone = 1;
      tick();
      serviceDone = 0; HLDA = 0;
      checks++; if (DACK !== 4'b0 || HRQ !== 1'b0 || grantValid !== 1'b0) begin failures++; $display("FAIL fixed_done[%0d] got dack=%b hrq=%0b gv=%0b want 0000/0/0", i, DACK, HRQ, grantValid); end
      checks++; if (priorityOrder !== 8'b11_10_01_00) begin failures++; $display("FAIL fixed_order[%0d] got=%b want=11100100", i, priorityOrder); end
      tick();
    end
  endtask

  task automatic test_rotating();
    logic [3:0] exps [3];
    logic [7:0] fin;
    exps = ROT_EN ? '{4'b0001, 4'b0010, 4'b0100} : '{4'b0001, 4'b0001, 4'b0001};
    fin  = ROT_EN ? 8'b10_01_00_11 : 8'b11_10_01_00;
    priorityType = 1;
    DREQ = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (HRQ !== 1'b1) begin failures++; $display("FAIL rot_hrq[%0d] got=%0b want=1", i, HRQ); end
      HLDA = 1;
      tick();
      checks++; if (DACK !== exps[i]) begin failures++; $display("FAIL rot_dack[%0d] got=%b want=%b", i, DACK, exps[i]); end
      serviceDone = 1;
      tick();
      serviceDone = 0; HLDA = 0;
      checks++; if (HRQ !== 1'b0 || DACK !== 4'b0) begin failures++; $display("FAIL rot_gap[%0d] got hrq=%0b dack=%b want 0/0000", i, HRQ, DACK); end
    end
    DREQ = 4'b0;
    checks++; if (priorityOrder !== fin) begin failures++; $display("FAIL rot_final_order got=%b want=%b", priorityOrder, fin); end
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] keep;
    keep = ROT_EN ? 8'b10_01_00_11 : 8'b11_10_01_00;
    priorityType = 1;
    DREQ = 4'b0100;
    tick();
    HLDA = 1;
    tick();
    checks++; if (DACK !== 4'b0100) begin failures++; $display("FAIL abort_grant got=%b want=0100", DACK); end
    HLDA = 0;
    tick();
    DREQ = 4'b0;
    checks++; if (DACK !== 4'b0 || HRQ !== 1'b0 || grantValid !== 1'b0) begin failures++; $display("FAIL abort_clear got dack=%b hrq=%0b gv=%0b want 0000/0/0", DACK, HRQ, grantValid); end
    checks++; if (priorityOrder !== keep) begin failures++; $display("FAIL abort_order got=%b want=%b", priorityOrder, keep); end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    priorityType = 1;
    DREQ = 4'b0010;
    tick();
    HLDA = 1;
    tick();
    checks++; if (DACK !== 4'b0010) begin failures++; $display("FAIL rst_mid_grant got=%b want=0010", DACK); end
    RESET = 1;
    tick();
    checks++; if (HRQ !== 1'b0 || DACK !== 4'b0 || grantValid !== 1'b0 || grantCh !== 2'd0) begin failures++; $display("FAIL rst_mid_outputs got hrq=%0b dack=%b gv=%0b gch=%0d want 0/0000/0/0", HRQ, DACK, grantValid, grantCh); end
    checks++; if (priorityOrder !== 8'b11_10_01_00) begin failures++; $display("FAIL rst_mid_order got=%b want=11100100", priorityOrder); end
    RESET = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_mask_sw();
    priorityType = 0;
    maskReg = 4'b0001; DREQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (HRQ !== 1'b0) begin failures++; $display("FAIL masked_hrq[%0d] got=%0b want=0", i, HRQ); end
    end
    swRequest = 4'b0100;
    tick();
    checks++; if (HRQ !== 1'b1) begin failures++; $display("FAIL sw_hrq got=%0b want=1", HRQ); end
    HLDA = 1;
    tick();
    checks++; if (DACK !== 4'b0100) begin failures++; $display("FAIL sw_dack got=%b want=0100", DACK); end
    serviceDone = 1; swRequest = 4'b0;
    tick();
    serviceDone = 0; HLDA = 0;
    ctrlDisable = 1; maskReg = 4'b0; swRequest = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (HRQ !== 1'b0 || DACK !== 4'b0) begin failures++; $display("FAIL disabled[%0d] got hrq=%0b dack=%b want 0/0000", i, HRQ, DACK); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dreq_sense();
    dreqSense = 1; DREQ = 4'b1101;
    tick();
    checks++; if (HRQ !== 1'b1) begin failures++; $display("FAIL sense_hrq got=%0b want=1", HRQ); end
    HLDA = 1;
    tick();
    checks++; if (DACK !== 4'b0010 || grantCh !== 2'd1) begin failures++; $display("FAIL sense_dack got=%b/%0d want=0010/1", DACK, grantCh); end
    serviceDone = 1; DREQ = 4'b1111;
    tick();
    idle_inputs();
    checks++; if (DACK !== 4'b0) begin failures++; $display("FAIL sense_done got=%b want=0000", DACK); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      RESET       = ($urandom_range(0, 149) == 0);
      DREQ        = 4'($urandom) & 4'($urandom);
      maskReg     = 4'($urandom) & 4'($urandom);
      swRequest   = ($urandom_range(0, 5) == 0) ? 4'($urandom) & 4'($urandom) : 4'b0;
      ctrlDisable = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) dreqSense = ~dreqSense;
      if ($urandom_range(0, 49) == 0) priorityType = ~priorityType;
      HLDA        = HRQ ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      serviceDone = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (HRQ !== m_hrq) begin failures++; $display("FAIL rand_hrq[%0d] got=%0b want=%0b", n, HRQ, m_hrq); end
      checks++; if (DACK !== m_dack) begin failures++; $display("FAIL rand_dack[%0d] got=%b want=%b", n, DACK, m_dack); end
      checks++; if (grantValid !== m_gv) begin failures++; $display("FAIL rand_gv[%0d] got=%0b want=%0b", n, grantValid, m_gv); end
      checks++; if (priorityOrder !== model_order()) begin failures++; $display("FAIL rand_order[%0d] got=%b want=%b", n, priorityOrder, model_order()); end
      if (m_gv) begin
        checks++; if (grantCh !== 2'(m_gch)) begin failures++; $display("FAIL rand_gch[%0d] got=%0d want=%0d", n, grantCh, m_gch); end
      end
      checks++; if (!$onehot0(DACK) || (DACK != 4'b0 && !m_prev_hlda)) begin failures++; $display("FAIL rand_dack_legal[%0d] got=%b prev_hlda=%0b", n, DACK, m_prev_hlda); end
    end
    RESET = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed();
    test_rotating();
    test_abort();
    test_reset_mid_grant();
    test_mask_sw();
    test_dreq_sense();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
